// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: Moore main-control FSM for the multicycle MIPS datapath.
// Optional macro ADDI_EN adds the addi instruction (states ADDI_EX/ADDI_WB).
`default_nettype none

module mips_multicycle_control #(
    parameter int OPC_W = 6,
    parameter int ST_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [0:OPC_W-1] opcode,
    input  logic             zero,
    input  logic             memReady,
    output logic [0:1]       OpALU,
    output logic             ALUSrcA,
    output logic [0:1]       ALUSrcB,
    output logic [0:1]       PCSource,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             RegDst,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             pcEn,
    output logic             illegalOp,
    output logic [0:ST_W-1]  state
);

    typedef enum logic [ST_W-1:0] {
        FETCH    = ST_W'(0),
        DECODE   = ST_W'(1),
        MEMADR   = ST_W'(2),
        MEMREAD  = ST_W'(3),
        MEMWB    = ST_W'(4),
        MEMWRITE = ST_W'(5),
        EXEC     = ST_W'(6),
        RWB      = ST_W'(7),
        BRANCH   = ST_W'(8),
        JUMP     = ST_W'(9),
        ADDI_EX  = ST_W'(10),
        ADDI_WB  = ST_W'(11)
    } state_t;

    localparam logic [OPC_W-1:0] OP_LW   = OPC_W'(6'b100011);
    localparam logic [OPC_W-1:0] OP_SW   = OPC_W'(6'b101011);
    localparam logic [OPC_W-1:0] OP_RTYP = OPC_W'(6'b000000);
    localparam logic [OPC_W-1:0] OP_BEQ  = OPC_W'(6'b000100);
    localparam logic [OPC_W-1:0] OP_J    = OPC_W'(6'b000010);
    localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(6'b001000);

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

    // Outputs are gated by rst_n so no enable survives the instant reset asserts.
    always_comb begin
        state_d     = FETCH;
        OpALU       = 2'b00;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        PCSource    = 2'b00;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        illegalOp   = 1'b0;
        case (state_q)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = memReady;
                PCWrite = memReady;
                state_d = memReady ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYP:      state_d = EXEC;
                    OP_BEQ:       state_d = BRANCH;
                    OP_J:         state_d = JUMP;
`ifdef ADDI_EN
                    OP_ADDI:      state_d = ADDI_EX;
`endif
                    default: begin
                        illegalOp = 1'b1;
                        state_d   = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                if (opcode == OP_SW) begin
                    state_d = MEMWRITE;
                end else if (opcode == OP_LW) begin
                    state_d = MEMREAD;
                end else begin
                    state_d = FETCH;
                end
            end
            MEMREAD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                state_d = memReady ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            MEMWRITE: begin
                IorD     = 1'b1;
                MemWrite = memReady;
                state_d  = memReady ? FETCH : MEMWRITE;
            end
            EXEC: begin
                ALUSrcA = 1'b1;
                OpALU   = 2'b10;
                state_d = RWB;
            end
            RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                OpALU       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
`ifdef ADDI_EN
            ADDI_EX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = ADDI_WB;
            end
            ADDI_WB: begin
                RegWrite = 1'b1;
            end
`endif
            default: begin
                state_d = FETCH;
            end
        endcase
        if (!rst_n) begin
            OpALU       = 2'b00;
            ALUSrcA     = 1'b0;
            ALUSrcB     = 2'b00;
            PCSource    = 2'b00;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            MemtoReg    = 1'b0;
            RegWrite    = 1'b0;
            RegDst      = 1'b0;
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            illegalOp   = 1'b0;
        end
        pcEn = PCWrite | (PCWriteCond & zero);
    end

endmodule

`default_nettype wire

// File: tb/tb_mips_multicycle_control.sv
// tb_mips_multicycle_control: random instruction streams checked against an instruction-level model.
`default_nettype none

module tb_mips_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [0:5] opcode;
    logic       zero;
    logic       memReady;
    logic [0:1] OpALU, ALUSrcB, PCSource;
    logic       ALUSrcA, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite, RegDst;
    logic       PCWrite, PCWriteCond, pcEn, illegalOp;
    logic [0:3] state;

    int n_pass  = 0;
    int n_total = 0;

    mips_multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .memReady(memReady),
        .OpALU(OpALU), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .RegDst(RegDst), .PCWrite(PCWrite),
        .PCWriteCond(PCWriteCond), .pcEn(pcEn), .illegalOp(illegalOp), .state(state)
    );

    always #5 clk = ~clk;

    wire [17:0] dut_ctrl = {OpALU, ALUSrcA, ALUSrcB, PCSource, IorD, MemRead, MemWrite,
                            IRWrite, MemtoReg, RegWrite, RegDst, PCWrite, PCWriteCond,
                            pcEn, illegalOp};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic bit is_legal(input logic [5:0] opc);
        bit ok;
        ok = (opc == 6'b100011) || (opc == 6'b101011) || (opc == 6'b000000) ||
             (opc == 6'b000100) || (opc == 6'b000010);
`ifdef ADDI_EN
        ok = ok || (opc == 6'b001000);
`endif
        return ok;
    endfunction

    // Expected control word for one cycle, straight from the per-state output table.
    function automatic logic [17:0] exp_ctrl(input int st, input bit rdy, input bit z,
                                             input logic [5:0] opc);
        logic [1:0] op_alu, src_b, pc_src;
        logic src_a, iord, mrd, mwr, irw, m2r, rw, rdst, pcw, pcwc, ill;
        {op_alu, src_b, pc_src} = '0;
        {src_a, iord, mrd, mwr, irw, m2r, rw, rdst, pcw, pcwc, ill} = '0;
        case (st)
            0:  begin mrd = 1; src_b = 2'b01; irw = rdy; pcw = rdy; end
            1:  begin src_b = 2'b11; ill = !is_legal(opc); end
            2:  begin src_a = 1; src_b = 2'b10; end
            3:  begin mrd = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin iord = 1; mwr = rdy; end
            6:  begin src_a = 1; op_alu = 2'b10; end
            7:  begin rw = 1; rdst = 1; end
            8:  begin src_a = 1; op_alu = 2'b01; pcwc = 1; pc_src = 2'b01; end
            9:  begin pcw = 1; pc_src = 2'b10; end
`ifdef ADDI_EN
            10: begin src_a = 1; src_b = 2'b10; end
            11: begin rw = 1; end
`endif
            default: ;
        endcase
        return {op_alu, src_a, src_b, pc_src, iord, mrd, mwr, irw, m2r, rw, rdst,
                pcw, pcwc, pcw | (pcwc & z), ill};
    endfunction

    task automatic do_step(input int st, input bit rdy, input logic [5:0] opc);
        bit z;
        @(negedge clk);
        z        = 1'($urandom);
        memReady = rdy;
        zero     = z;
        opcode   = opc;
        #1;
        check($sformatf("state(exp %0d)", st), 32'(state), 32'(st));
        check($sformatf("ctrl@st%0d", st), 32'(dut_ctrl), 32'(exp_ctrl(st, rdy, z, opc)));
    endtask

    function automatic logic [5:0] rnd_opc();
        return 6'($urandom);
    endfunction

    // Instruction-level model: the state walk follows the instruction class and stall counts.
    task automatic run_instr(input logic [5:0] opc, input int kf, input int km);
        for (int i = 0; i < kf; i++) do_step(0, 0, rnd_opc());
        do_step(0, 1, rnd_opc());
        do_step(1, 1'($urandom), opc);
        if (!is_legal(opc)) return;
        case (opc)
            6'b100011: begin
                do_step(2, 1'($urandom), opc);
                for (int i = 0; i < km; i++) do_step(3, 0, rnd_opc());
                do_step(3, 1, rnd_opc());
                do_step(4, 1'($urandom), rnd_opc());
            end
            6'b101011: begin
                do_step(2, 1'($urandom), opc);
                for (int i = 0; i < km; i++) do_step(5, 0, rnd_opc());
                do_step(5, 1, rnd_opc());
            end
            6'b000000: begin
                do_step(6, 1'($urandom), rnd_opc());
                do_step(7, 1'($urandom), rnd_opc());
            end
            6'b000100: do_step(8, 1'($urandom), rnd_opc());
            6'b000010: do_step(9, 1'($urandom), rnd_opc());
            default: begin
                do_step(10, 1'($urandom), rnd_opc());
                do_step(11, 1'($urandom), rnd_opc());
            end
        endcase
    endtask

    function automatic logic [5:0] pick_opc();
        logic [5:0] o;
        case ($urandom_range(0, 7))
            0: o = 6'b100011;
            1: o = 6'b101011;
            2: o = 6'b000000;
            3: o = 6'b000100;
            4: o = 6'b000010;
            5: o = 6'b001000;
            6: o = 6'b111111;
            default: begin
                o = 6'($urandom);
                while (is_legal(o) || o == 6'b001000) o = 6'($urandom);
            end
        endcase
        return o;
    endfunction

    initial begin
        rst_n    = 1'b0;
        memReady = 1'b1;
        zero     = 1'b1;
        opcode   = 6'b100011;
        #2;
        check("reset_state", 32'(state), 32'd0);
        check("reset_ctrl", 32'(dut_ctrl), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed: each class once with stalls, then reset mid-EXEC.
        run_instr(6'b100011, 0, 0);
        run_instr(6'b101011, 1, 3);
        run_instr(6'b000000, 0, 0);
        run_instr(6'b000100, 0, 0);
        run_instr(6'b000010, 0, 0);
        run_instr(6'b111111, 0, 0);
        run_instr(6'b001000, 0, 0);

        do_step(0, 1, rnd_opc());
        do_step(1, 1, 6'b000000);
        do_step(6, 1, rnd_opc());
        #1;
        rst_n    = 1'b0;
        memReady = 1'b1;
        zero     = 1'b1;
        #1;
        check("midexec_rst_state", 32'(state), 32'd0);
        check("midexec_rst_ctrl", 32'(dut_ctrl), 32'd0);
        @(posedge clk);
        #1;
        check("held_rst_ctrl", 32'(dut_ctrl), 32'd0);
        #1 rst_n = 1'b1;
        run_instr(6'b100011, 2, 1);

        for (int n = 0; n < 300; n++) begin
            run_instr(pick_opc(), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Main control unit for the multicycle MIPS datapath.
- Drives the other end of the ALU-control interface: produces OpALU (00 add, 01 sub, 10 decode funct) for the existing ALU-control decoder.
- Also drives all datapath enables and multiplexer selects from the 6-bit opcode.
- Moore FSM, with write-enable gating on a memory ready handshake.

Parameters:
- OPC_W, 6, opcode width.
- ST_W, 4, state register width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- opcode  input  [0:5]  instruction bits 31..26 from the instruction register.
- zero  input  1  ALU zero flag.
- memReady  input  1  memory completes the current access this cycle.
- OpALU  output  [0:1]  to the ALU-control decoder.
- ALUSrcA  output  1  0=PC, 1=regA.
- ALUSrcB  output  [0:1]  00=regB, 01=const 4, 10=signext imm, 11=signext imm<<2.
- PCSource  output  [0:1]  00=ALU result, 01=ALUOut, 10=jump target.
- IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite, RegDst  output  1 each  standard datapath controls.
- PCWrite, PCWriteCond  output  1 each  PC update controls.
- pcEn  output  1  PCWrite | (PCWriteCond & zero).
- illegalOp  output  1  one-cycle pulse on an unknown opcode.
- state  output  [0:3]  current state, for debug.

Behaviour:
- Reset:
  - rst_n=0 forces state=FETCH(0) immediately.
  - While rst_n=0, every output is 0, including MemRead, all write enables, pcEn and illegalOp.
  - After deassertion, the first rising edge sees FETCH with normal outputs.
- States (encoding) -> outputs -> next state:
  - FETCH(0): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, OpALU=00, PCSource=00. IRWrite=PCWrite=memReady. memReady=1 -> DECODE; otherwise stay.
  - DECODE(1): ALUSrcA=0, ALUSrcB=11, OpALU=00. Next by opcode:
    - 100011 lw -> MEMADR.
    - 101011 sw -> MEMADR.
    - 000000 R-type -> EXEC.
    - 000100 beq -> BRANCH.
    - 000010 j -> JUMP.
    - 001000 addi -> ADDI_EX (only with the feature).
    - Anything else: illegalOp=1 for this cycle only -> FETCH.
  - MEMADR(2): ALUSrcA=1, ALUSrcB=10, OpALU=00. lw -> MEMREAD; sw -> MEMWRITE.
  - MEMREAD(3): MemRead=1, IorD=1. Stay until memReady=1 -> MEMWB.
  - MEMWB(4): RegWrite=1, MemtoReg=1, RegDst=0 -> FETCH.
  - MEMWRITE(5): IorD=1. MemWrite=memReady. memReady=1 -> FETCH; otherwise stay.
  - EXEC(6): ALUSrcA=1, ALUSrcB=00, OpALU=10 -> RWB.
  - RWB(7): RegWrite=1, RegDst=1, MemtoReg=0 -> FETCH.
  - BRANCH(8): ALUSrcA=1, ALUSrcB=00, OpALU=01, PCWriteCond=1, PCSource=01 -> FETCH.
  - JUMP(9): PCWrite=1, PCSource=10 -> FETCH.
  - States 10..15 (no feature) -> FETCH, all outputs 0.
- Output rules:
  - Outputs not listed for a state are 0.
  - All outputs are combinational from state; memReady gating applies only where stated.
- Latency in cycles, with memReady=1 throughout: lw 5, sw 4, R-type 4, beq 3, j 3, addi 4.
- Each memReady=0 cycle in FETCH/MEMREAD/MEMWRITE adds one cycle. No write enable pulses during a stall.
- opcode is sampled only in DECODE and MEMADR. Changes in any other state are ignored.
- Reset mid-instruction abandons it. No partial write may follow: enables drop the same instant rst_n falls.

Optional Feature:
- Macro ADDI_EN.
- Defined:
  - opcode 001000 is legal.
  - ADDI_EX(10): ALUSrcA=1, ALUSrcB=10, OpALU=00 -> ADDI_WB.
  - ADDI_WB(11): RegWrite=1, RegDst=0, MemtoReg=0 -> FETCH.
- Undefined: 001000 is illegal (illegalOp pulse in DECODE, then FETCH). States 10/11 are unreachable.

Test Plan:
- Reset: rst_n=0 mid-EXEC -> state=0 and all outputs 0 immediately. Release -> FETCH with MemRead=1; IRWrite=1 only once memReady=1.
- lw (opcode 100011), memReady=1 -> states 0,1,2,3,4,0. RegWrite=1 and MemtoReg=1 only in state 4. Total 5 cycles.
- sw (101011) with memReady=0 for 3 cycles in MEMWRITE -> state 5 held 4 cycles; MemWrite=1 only in the final cycle; then FETCH.
- R-type (000000) -> OpALU=10 in EXEC, RegDst=1 and RegWrite=1 in RWB.
- beq (000100):
  - zero=1 -> pcEn=1 in BRANCH with OpALU=01.
  - zero=0 -> pcEn=0.
  - j (000010) -> PCWrite=1, PCSource=10.
- opcode 111111 -> illegalOp high exactly 1 cycle in DECODE, then FETCH.
- 001000 with ADDI_EN -> states 10,11, RegWrite=1.
- 001000 without ADDI_EN -> illegalOp=1.
